// File: rtl/inst_fifo_if.sv
// Instruction FIFO port bundle: host push side, decode-stage pop side, status.
// No timing of its own; pure wiring between the host, the FIFO and decode.
// Flow control is level-based: wr_en is dropped by the FIFO while full is high.
// The overrun_err/underrun_err flags exist only when INST_FIFO_ERR_EN is defined.
interface inst_fifo_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 82
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
`ifdef INST_FIFO_ERR_EN
  logic             overrun_err;
  logic             underrun_err;
`endif

`ifdef INST_FIFO_ERR_EN
  modport master (output wr_en, wr_data, rd_en,
                  input  rd_data, empty, full, count, overrun_err, underrun_err);
  modport slave  (input  wr_en, wr_data, rd_en,
                  output rd_data, empty, full, count, overrun_err, underrun_err);
`else
  modport master (output wr_en, wr_data, rd_en,
                  input  rd_data, empty, full, count);
  modport slave  (input  wr_en, wr_data, rd_en,
                  output rd_data, empty, full, count);
`endif
endinterface

// File: rtl/inst_fifo.sv
// Instruction FIFO between host command interface and decode stage (FWFT, DEPTH x WIDTH).
// Latency: push visible on rd_data one edge later; rd_data is combinational off the head entry.
// Backpressure: pushes dropped while full, pops ignored while empty; optional sticky
// overrun_err/underrun_err flags when INST_FIFO_ERR_EN is defined.
// DEPTH must be a power of two (>= 2) so the pointers wrap by natural overflow.
module inst_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 82
) (
  input  logic        clk,
  input  logic        n_rst,
  inst_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count_q;
  logic             empty_w;
  logic             full_w;
  logic             push_ok;
  logic             pop_ok;

  // Status flags come straight from the registered occupancy count.
  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == FULL_CNT);

  // Full blocks a push even if a pop lands in the same cycle; empty blocks
  // only the pop, so a push into an empty FIFO still goes through.
  assign push_ok = bus.wr_en & ~full_w;
  assign pop_ok  = bus.rd_en & ~empty_w;

  // Storage array: written on accepted pushes only, never reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= bus.wr_data;
    end
  end

  // Pointers and occupancy count; reset discards all stored entries.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // First-word-fall-through head; forced to zero while empty so decode never
  // sees stale storage contents.
  assign bus.rd_data = empty_w ? '0 : mem[rptr];
  assign bus.empty   = empty_w;
  assign bus.full    = full_w;
  assign bus.count   = count_q;

`ifdef INST_FIFO_ERR_EN
  logic overrun_q;
  logic underrun_q;

  // Sticky error flags: set by any attempted push-while-full or
  // pop-while-empty, cleared only by reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (bus.wr_en && full_w)  overrun_q  <= 1'b1;
      if (bus.rd_en && empty_w) underrun_q <= 1'b1;
    end
  end

  assign bus.overrun_err  = overrun_q;
  assign bus.underrun_err = underrun_q;
`endif

endmodule

// File: tb/tb_inst_fifo.sv
// Self-checking bench for inst_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model of the FIFO.
// Error-flag scenario is compiled in when INST_FIFO_ERR_EN is defined.
module tb_inst_fifo;
  localparam int DEPTH = 8;
  localparam int WIDTH = 82;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk;
  logic n_rst;

  inst_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  inst_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: plain queue of stored words plus sticky error bits.
  logic [WIDTH-1:0] q[$];
  logic             ovr_m;
  logic             und_m;

  function automatic logic [WIDTH-1:0] exp_head();
    return (q.size() == 0) ? '0 : q[0];
  endfunction

  function automatic logic [WIDTH-1:0] rnd_word();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[WIDTH-1:0];
  endfunction

  // Drive one cycle of stimulus and advance the model by the FIFO rules.
  task automatic step(input logic we, input logic [WIDTH-1:0] wd, input logic re);
    bit was_full, was_empty;
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (we && was_full)  ovr_m = 1'b1;
    if (re && was_empty) und_m = 1'b1;
    if (re && !was_empty) void'(q.pop_front());
    if (we && !was_full)  q.push_back(wd);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wr_data = '0;
    q.delete(); ovr_m = 1'b0; und_m = 1'b0;
    #1;
    tests++; if (bus.count !== '0) begin fails++; $display("FAIL reset_count got %0d want 0", bus.count); end
    tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", bus.empty); end
    tests++; if (bus.full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", bus.full); end
    tests++; if (bus.rd_data !== '0) begin fails++; $display("FAIL reset_rd_data got %h want 0", bus.rd_data); end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_single();
    step(1'b1, WIDTH'(1), 1'b0);
    tests++; if (bus.rd_data !== WIDTH'(1)) begin fails++; $display("FAIL single_data got %h want 1", bus.rd_data); end
    tests++; if (bus.empty !== 1'b0) begin fails++; $display("FAIL single_empty got %b want 0", bus.empty); end
    tests++; if (bus.count !== CW'(1)) begin fails++; $display("FAIL single_count got %0d want 1", bus.count); end
    step(1'b0, '0, 1'b1);
    tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL single_pop_empty got %b want 1", bus.empty); end
    tests++; if (bus.rd_data !== '0) begin fails++; $display("FAIL single_pop_data got %h want 0", bus.rd_data); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(32'h10 + i), 1'b0);
    tests++; if (bus.full !== 1'b1) begin fails++; $display("FAIL fill_full got %b want 1", bus.full); end
    tests++; if (bus.count !== CW'(DEPTH)) begin fails++; $display("FAIL fill_count got %0d want %0d", bus.count, DEPTH); end
    step(1'b1, WIDTH'(32'h99), 1'b0);
    tests++; if (bus.count !== CW'(DEPTH)) begin fails++; $display("FAIL fill_drop_count got %0d want %0d", bus.count, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      tests++;
      if (bus.rd_data !== WIDTH'(32'h10 + i)) begin
        fails++; $display("FAIL fill_order[%0d] got %h want %h", i, bus.rd_data, 32'h10 + i);
      end
      step(1'b0, '0, 1'b1);
    end
    tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL fill_drained got %b want 1", bus.empty); end
  endtask

  task automatic test_both_at_limits();
    for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(32'h20 + i), 1'b0);
    step(1'b1, WIDTH'(32'h99), 1'b1);
    tests++; if (bus.count !== CW'(DEPTH - 1)) begin fails++; $display("FAIL full_both_count got %0d want %0d", bus.count, DEPTH - 1); end
    tests++; if (bus.rd_data !== WIDTH'(32'h21)) begin fails++; $display("FAIL full_both_head got %h want 21", bus.rd_data); end
    for (int i = 1; i < DEPTH; i++) begin
      tests++;
      if (bus.rd_data !== WIDTH'(32'h20 + i)) begin
        fails++; $display("FAIL full_both_drain[%0d] got %h want %h", i, bus.rd_data, 32'h20 + i);
      end
      step(1'b0, '0, 1'b1);
    end
    tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL full_both_no99 empty got %b want 1", bus.empty); end
    step(1'b1, WIDTH'(32'h55), 1'b1);
    tests++; if (bus.count !== CW'(1)) begin fails++; $display("FAIL empty_both_count got %0d want 1", bus.count); end
    tests++; if (bus.rd_data !== WIDTH'(32'h55)) begin fails++; $display("FAIL empty_both_data got %h want 55", bus.rd_data); end
    step(1'b0, '0, 1'b1);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) step(1'b1, rnd_word(), 1'b0);
    for (int c = 0; c < 20; c++) begin
      step(1'b1, rnd_word(), 1'b1);
      tests++; if (bus.count !== CW'(3)) begin fails++; $display("FAIL wrap_count[%0d] got %0d want 3", c, bus.count); end
      tests++; if (bus.rd_data !== exp_head()) begin fails++; $display("FAIL wrap_data[%0d] got %h want %h", c, bus.rd_data, exp_head()); end
    end
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      step(($urandom_range(0, 99) < 55), rnd_word(), ($urandom_range(0, 99) < 50));
      tests++; if (bus.count !== CW'(q.size())) begin fails++; $display("FAIL rand_count[%0d] got %0d want %0d", c, bus.count, q.size()); end
      tests++; if (bus.rd_data !== exp_head()) begin fails++; $display("FAIL rand_data[%0d] got %h want %h", c, bus.rd_data, exp_head()); end
      tests++; if (bus.empty !== (q.size() == 0)) begin fails++; $display("FAIL rand_empty[%0d] got %b want %b", c, bus.empty, q.size() == 0); end
      tests++; if (bus.full !== (q.size() == DEPTH)) begin fails++; $display("FAIL rand_full[%0d] got %b want %b", c, bus.full, q.size() == DEPTH); end
`ifdef INST_FIFO_ERR_EN
      tests++; if (bus.overrun_err !== ovr_m) begin fails++; $display("FAIL rand_ovr[%0d] got %b want %b", c, bus.overrun_err, ovr_m); end
      tests++; if (bus.underrun_err !== und_m) begin fails++; $display("FAIL rand_und[%0d] got %b want %b", c, bus.underrun_err, und_m); end
`endif
    end
  endtask

  task automatic test_async_reset();
    while (q.size() != 0) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, rnd_word(), 1'b0);
    tests++; if (bus.count !== CW'(5)) begin fails++; $display("FAIL arst_pre_count got %0d want 5", bus.count); end
    bus.wr_en = 1'b1; bus.wr_data = rnd_word();
    #2;
    n_rst = 1'b0;
    q.delete(); ovr_m = 1'b0; und_m = 1'b0;
    #1;
    tests++; if (bus.count !== '0) begin fails++; $display("FAIL arst_count got %0d want 0", bus.count); end
    tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL arst_empty got %b want 1", bus.empty); end
    tests++; if (bus.full !== 1'b0) begin fails++; $display("FAIL arst_full got %b want 0", bus.full); end
    tests++; if (bus.rd_data !== '0) begin fails++; $display("FAIL arst_rd_data got %h want 0", bus.rd_data); end
`ifdef INST_FIFO_ERR_EN
    tests++; if (bus.overrun_err !== 1'b0) begin fails++; $display("FAIL arst_ovr got %b want 0", bus.overrun_err); end
    tests++; if (bus.underrun_err !== 1'b0) begin fails++; $display("FAIL arst_und got %b want 0", bus.underrun_err); end
`endif
    bus.wr_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    step(1'b1, WIDTH'(32'h2A), 1'b0);
    tests++; if (bus.rd_data !== WIDTH'(32'h2A)) begin fails++; $display("FAIL arst_push_data got %h want 2a", bus.rd_data); end
    tests++; if (bus.count !== CW'(1)) begin fails++; $display("FAIL arst_push_count got %0d want 1", bus.count); end
    step(1'b0, '0, 1'b1);
  endtask

`ifdef INST_FIFO_ERR_EN
  task automatic test_errors();
    tests++; if (bus.underrun_err !== 1'b0) begin fails++; $display("FAIL err_und_init got %b want 0", bus.underrun_err); end
    step(1'b0, '0, 1'b1);
    tests++; if (bus.underrun_err !== 1'b1) begin fails++; $display("FAIL err_und_set got %b want 1", bus.underrun_err); end
    tests++; if (bus.overrun_err !== 1'b0) begin fails++; $display("FAIL err_ovr_init got %b want 0", bus.overrun_err); end
    for (int i = 0; i < DEPTH; i++) step(1'b1, rnd_word(), 1'b0);
    step(1'b1, WIDTH'(32'h99), 1'b0);
    tests++; if (bus.overrun_err !== 1'b1) begin fails++; $display("FAIL err_ovr_set got %b want 1", bus.overrun_err); end
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);
    tests++; if (bus.overrun_err !== 1'b1) begin fails++; $display("FAIL err_ovr_sticky got %b want 1", bus.overrun_err); end
    tests++; if (bus.underrun_err !== 1'b1) begin fails++; $display("FAIL err_und_sticky got %b want 1", bus.underrun_err); end
    n_rst = 1'b0;
    q.delete(); ovr_m = 1'b0; und_m = 1'b0;
    #1;
    tests++; if (bus.overrun_err !== 1'b0) begin fails++; $display("FAIL err_ovr_clear got %b want 0", bus.overrun_err); end
    tests++; if (bus.underrun_err !== 1'b0) begin fails++; $display("FAIL err_und_clear got %b want 0", bus.underrun_err); end
    @(negedge clk);
    n_rst = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_both_at_limits();
    test_wrap();
    test_random();
    test_async_reset();
`ifdef INST_FIFO_ERR_EN
    test_errors();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout got no completion want finish before limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/inst_fifo.md
INST_FIFO -- requirements
Module: inst_fifo

Interface
REQ-001 Parameter DEPTH, default 8: number of instruction entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter WIDTH, default 82: instruction word width in bits; bit 0 is the instruction-type bit consumed by the decode stage.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 n_rst  input  1  reset, asynchronous and active-low.
REQ-005 wr_en  input  1  push request from the host/command interface.
REQ-006 wr_data  input  WIDTH  instruction word to push.
REQ-007 rd_en  input  1  pop request from the decode stage.
REQ-008 rd_data  output  WIDTH  head instruction word, feeding the decode stage's fifo_data input.
REQ-009 empty  output  1  high when no entries are stored.
REQ-010 full  output  1  high when DEPTH entries are stored.
REQ-011 count  output  log2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-012 overrun_err  output  1  sticky push-while-full flag; present only under INST_FIFO_ERR_EN.
REQ-013 underrun_err  output  1  sticky pop-while-empty flag; present only under INST_FIFO_ERR_EN.

Function
REQ-014 Storage SHALL be a DEPTH x WIDTH circular buffer with write pointer wptr and read pointer rptr, each log2(DEPTH) bits.
REQ-015 A push SHALL be accepted when wr_en=1 and full=0: the word is stored at wptr and wptr advances by 1.
REQ-016 A pop SHALL be accepted when rd_en=1 and empty=0: rptr advances by 1.
REQ-017 Pointers SHALL wrap from DEPTH-1 to 0 without a gap.
REQ-018 The block SHALL be first-word-fall-through: rd_data equals the entry at rptr whenever empty=0, with no read latency.
REQ-019 rd_data SHALL be all zeros whenever empty=1.
REQ-020 A word pushed on cycle N SHALL appear on rd_data, with empty=0, after the clock edge ending cycle N; write-to-read latency is 1 cycle.
REQ-021 count SHALL update on the same edge as the accepted operation: +1 on push only, -1 on pop only, unchanged on push and pop together or when neither is accepted.
REQ-022 empty SHALL equal (count==0) and full SHALL equal (count==DEPTH); both are derived from registered state.
REQ-023 When full=1, a push SHALL be rejected even if a pop is accepted in the same cycle; data and wptr stay unchanged, and count goes to DEPTH-1.
REQ-024 When empty=1, a pop SHALL be ignored and a simultaneous push SHALL be accepted; count goes to 1.
REQ-025 A rejected push or pop SHALL NOT alter any stored entry, pointer or count.
REQ-026 Data order SHALL be strictly first-in first-out across any number of pointer wraps.

Reset
REQ-027 While n_rst=0, the block SHALL force wptr=0, rptr=0, count=0, empty=1, full=0, rd_data=0, overrun_err=0 and underrun_err=0, independent of clk.
REQ-028 Reset asserted mid-operation SHALL discard all stored entries; storage array contents need not be cleared.
REQ-029 After n_rst deasserts, the first rising edge SHALL already accept a push.

Configuration
REQ-030 With macro INST_FIFO_ERR_EN defined, overrun_err SHALL set on the edge after any cycle with wr_en=1 and full=1.
REQ-031 With INST_FIFO_ERR_EN defined, underrun_err SHALL set on the edge after any cycle with rd_en=1 and empty=1.
REQ-032 With INST_FIFO_ERR_EN defined, both error flags SHALL stay set until n_rst=0.
REQ-033 Without INST_FIFO_ERR_EN, both error ports SHALL be absent and rejected operations SHALL be silently dropped; all other behaviour is identical.

Verification
REQ-034 Reset, then push 0x1 -> next cycle: rd_data=0x1, empty=0, count=1; pop -> next cycle: empty=1, rd_data=0.
REQ-035 Push 8 words 0x10..0x17 (DEPTH=8) -> full=1, count=8; a ninth push of 0x99 is dropped; 8 pops return 0x10..0x17 in order.
REQ-036 Wrap test: run 20 cycles with continuous push and pop at count=3 -> count stays 3 and the output sequence matches the input delayed by 3 entries.
REQ-037 At full, wr_en=1 and rd_en=1 together -> count=7, head advances, 0x99 not stored; at empty, both asserted -> count=1, rd_data equals the pushed word.
REQ-038 Assert n_rst=0 mid-burst at count=5 -> outputs take reset values immediately (asynchronously); after release, push 0x2A -> rd_data=0x2A.
REQ-039 With INST_FIFO_ERR_EN: pop when empty -> underrun_err=1; fill, then push -> overrun_err=1; both stay 1 through 10 idle cycles and clear on reset.
